pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register; the next generation of the fetch/decode boundary register, usable at any stage boundary of the RISC-V core. It carries a PC and an instruction word with a valid/ready handshake. It adds stall hold, flush with NOP bubble insertion, and an optional 2-entry skid buffer that breaks the combinational ready path. It sits between a producer stage (e.g. fetch) and a consumer stage (e.g. decode).

---
 rtl/pipe_stage_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying PC + instruction with valid/ready, stall, flush-to-NOP bubble.
// Define PIPE_REG_SKID_EN to add a second (skid) entry that removes the out_ready -> in_ready path.
module pipe_stage_reg #(
   parameter int                 PC_W      = 32,
   parameter int                 INSTR_W   = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013,
   parameter logic [PC_W-1:0]    RESET_PC  = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    pc_in,
   input  logic [INSTR_W-1:0] instruction_in,
   input  logic               stall,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    pc_out,
   output logic [INSTR_W-1:0] instruction_out,
   output logic               bubble_out
);

   logic               accept;
   logic               drain;

   logic               out_valid_n;
   logic [PC_W-1:0]    pc_out_n;
   logic [INSTR_W-1:0] instruction_out_n;
   logic               bubble_out_n;

   assign accept = in_valid && in_ready;
   assign drain  = out_valid && out_ready;

`ifdef PIPE_REG_SKID_EN

   logic               skid_valid;
   logic [PC_W-1:0]    skid_pc;
   logic [INSTR_W-1:0] skid_instr;
   logic               ready_q;

   logic               skid_valid_n;
   logic [PC_W-1:0]    skid_pc_n;
   logic [INSTR_W-1:0] skid_instr_n;
   logic               ready_q_n;

   // ready_q mirrors "skid empty" so the producer never sees out_ready combinationally
   assign in_ready = ready_q && !stall && !flush;

   always_comb begin
      out_valid_n       = out_valid;
      pc_out_n          = pc_out;
      instruction_out_n = instruction_out;
      bubble_out_n      = bubble_out;
      skid_valid_n      = skid_valid;
      skid_pc_n         = skid_pc;
      skid_instr_n      = skid_instr;

      if (flush) begin
         out_valid_n       = 1'b0;
         instruction_out_n = NOP_INSTR;
         bubble_out_n      = 1'b1;
         skid_valid_n      = 1'b0;
      end else if (drain) begin
         if (skid_valid) begin
            pc_out_n          = skid_pc;
            instruction_out_n = skid_instr;
            bubble_out_n      = 1'b0;
            if (accept) begin
               skid_pc_n    = pc_in;
               skid_instr_n = instruction_in;
            end else begin
               skid_valid_n = 1'b0;
            end
         end else if (accept) begin
            pc_out_n          = pc_in;
            instruction_out_n = instruction_in;
            bubble_out_n      = 1'b0;
         end else begin
            out_valid_n = 1'b0;
         end
      end else if (accept) begin
         // Consumer is holding a full output, so the new beat parks in the skid
         if (!out_valid) begin
            out_valid_n       = 1'b1;
            pc_out_n          = pc_in;
            instruction_out_n = instruction_in;
            bubble_out_n      = 1'b0;
         end else begin
            skid_valid_n = 1'b1;
            skid_pc_n    = pc_in;
            skid_instr_n = instruction_in;
         end
      end

      ready_q_n = !skid_valid_n;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_instr <= NOP_INSTR;
         ready_q    <= 1'b1;
      end else begin
         skid_valid <= skid_valid_n;
         skid_pc    <= skid_pc_n;
         skid_instr <= skid_instr_n;
         ready_q    <= ready_q_n;
      end
   end

`else

   // Single entry: a full output can still take a beat when it drains in the same cycle
   assign in_ready = !stall && !flush && (!out_valid || out_ready);

   always_comb begin
      out_valid_n       = out_valid;
      pc_out_n          = pc_out;
      instruction_out_n = instruction_out;
      bubble_out_n      = bubble_out;

      if (flush) begin
         out_valid_n       = 1'b0;
         instruction_out_n = NOP_INSTR;
         bubble_out_n      = 1'b1;
      end else if (accept) begin
         out_valid_n       = 1'b1;
         pc_out_n          = pc_in;
         instruction_out_n = instruction_in;
         bubble_out_n      = 1'b0;
      end else if (drain) begin
         out_valid_n = 1'b0;
      end
   end

`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid       <= 1'b0;
         pc_out          <= RESET_PC;
         instruction_out <= NOP_INSTR;
         bubble_out      <= 1'b0;
      end else begin
         out_valid       <= out_valid_n;
         pc_out          <= pc_out_n;
         instruction_out <= instruction_out_n;
         bubble_out      <= bubble_out_n;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a queue models stage occupancy, a monitor checks every cycle.
module tb_pipe_stage_reg;

   localparam logic [31:0] NOP = 32'h00000013;
`ifdef PIPE_REG_SKID_EN
   localparam int CAPACITY = 2;
`else
   localparam int CAPACITY = 1;
`endif

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc_in;
   logic [31:0] instruction_in;
   logic        stall;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] pc_out;
   logic [31:0] instruction_out;
   logic        bubble_out;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] last_pc;
   logic [31:0] last_instr;
   logic        bubble_exp;
   logic        exp_ready_now;
   int          vectors;
   int          miscompares;

   pipe_stage_reg dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .pc_in           (pc_in),
      .instruction_in  (instruction_in),
      .stall           (stall),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .pc_out          (pc_out),
      .instruction_out (instruction_out),
      .bubble_out      (bubble_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then update the model just before the rising edge
   task automatic applyStimulus(input bit iv, input logic [31:0] p, input logic [31:0] i,
                                input bit st, input bit fl, input bit ordy);
      @(negedge clk);
      in_valid       = iv;
      pc_in          = p;
      instruction_in = i;
      stall          = st;
      flush          = fl;
      out_ready      = ordy;
      #4;
      if (reset) begin
         if (fl) begin
            exp_q.delete();
            last_instr = NOP;
            bubble_exp = 1'b1;
         end else begin
            if (iv && exp_ready_now) exp_q.push_back('{pc: p, instr: i});
            if (exp_q.size() > 0) begin
               last_pc    = exp_q[0].pc;
               last_instr = exp_q[0].instr;
               bubble_exp = 1'b0;
            end
         end
      end
   endtask

   // Monitor: compares the visible output against the model and retires drained beats
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (reset) begin
            exp_ready_now = !stall && !flush &&
                            ((CAPACITY == 1) ? (exp_q.size() == 0 || out_ready)
                                             : (exp_q.size() < CAPACITY));
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready_now});
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
               checkOutput("pc_out", pc_out, exp_q[0].pc);
               checkOutput("instruction_out", instruction_out, exp_q[0].instr);
               checkOutput("bubble_out", {31'd0, bubble_out}, 32'd0);
               if (out_ready && !flush) void'(exp_q.pop_front());
            end else begin
               checkOutput("pc_out_idle", pc_out, last_pc);
               checkOutput("instruction_out_idle", instruction_out, last_instr);
               checkOutput("bubble_out_idle", {31'd0, bubble_out}, {31'd0, bubble_exp});
            end
         end
      end
   end

   task automatic resetModel();
      exp_q.delete();
      last_pc    = 32'd0;
      last_instr = NOP;
      bubble_exp = 1'b0;
   endtask

   task automatic checkResetOutputs();
      checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_pc_out", pc_out, 32'd0);
      checkOutput("reset_instruction_out", instruction_out, NOP);
      checkOutput("reset_bubble_out", {31'd0, bubble_out}, 32'd0);
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      exp_ready_now  = 1'b0;
      reset          = 1'b0;
      in_valid       = 1'b0;
      pc_in          = '0;
      instruction_in = '0;
      stall          = 1'b0;
      flush          = 1'b0;
      out_ready      = 1'b0;
      resetModel();
      repeat (3) @(negedge clk);
      #1;
      checkResetOutputs();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

      // Streaming back-to-back
      applyStimulus(1, 32'h0, 32'hA, 0, 0, 1);
      applyStimulus(1, 32'h4, 32'hB, 0, 0, 1);
      applyStimulus(1, 32'h8, 32'hC, 0, 0, 1);
      applyStimulus(0, 32'h0, 32'h0, 0, 0, 1);
      applyStimulus(0, 32'h0, 32'h0, 0, 0, 1);

      // Backpressure with a beat held on the output
      applyStimulus(1, 32'h4, 32'hB, 0, 0, 0);
      repeat (3) applyStimulus(1, 32'h8, 32'hC, 0, 0, 0);
      repeat (4) applyStimulus(0, 32'h0, 32'h0, 0, 0, 1);

      // Stall: output drains once, nothing accepted
      applyStimulus(1, 32'h20, 32'h55, 0, 0, 1);
      repeat (3) applyStimulus(1, 32'h24, 32'h66, 1, 0, 1);

      // Flush with stage full and a beat offered, then recovery
      repeat (3) applyStimulus(1, 32'h30, 32'h77, 0, 0, 0);
      applyStimulus(1, 32'h34, 32'h88, 0, 1, 1);
      applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
      applyStimulus(1, 32'h38, 32'h99, 0, 0, 0);
      applyStimulus(0, 32'h0, 32'h0, 0, 0, 1);

      // Flush and stall together
      repeat (3) applyStimulus(1, 32'h40, 32'hAA, 0, 0, 0);
      applyStimulus(1, 32'h44, 32'hBB, 1, 1, 0);
      applyStimulus(0, 32'h0, 32'h0, 0, 0, 1);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 9) < 6);
      end

      // Reset asserted mid-stream while the output holds a beat
      applyStimulus(1, 32'h50, 32'hCC, 0, 0, 0);
      applyStimulus(1, 32'h54, 32'hDD, 0, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      checkResetOutputs();
      resetModel();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("in_ready_after_release", {31'd0, in_ready}, 32'd1);

      for (int n = 0; n < 300; n++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 9) < 6);
      end
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
